request_arbiter: RTL and testbench
==================================

Name: request_arbiter

Overview:
- Upstream conditioning stage for the traffic-light breadboard controller.
- Converts raw per-lane emergency-vehicle detector lines into a single arbitrated emergency request: emgSignal plus a one-hot emgLane, each held for a fixed number of cycles.
- Debounces and latches the pedestrian push-button into pedSignal.
- Outputs connect directly to the controller's emgSignal, emgLane and pedSignal inputs.

Parameters:
- HOLD_CYCLES, 4: cycles emgSignal/emgLane stay asserted per grant; legal range 1..255.
- GAP_CYCLES, 2: forced idle cycles after each grant, before the next grant; legal range 0..255.
- DEB_CYCLES, 3: consecutive high samples of pedButton required to register a request; legal range 1..255.

Ports:
- clk  in  1  system clock; rising-edge active.
- rst  in  1  synchronous, active-high reset.
- emgDetect  in  8  raw emergency detect, one bit per lane; bit order matches emgLane.
- pedButton  in  1  raw pedestrian button, level.
- pedClear  in  1  one-cycle pulse from the controller: pedestrian phase served.
- emgSignal  out  1  emergency request active.
- emgLane  out  8  one-hot granted lane; 0 when emgSignal=0.
- pedSignal  out  1  latched pedestrian request, masked by emergency.
- pending  out  8  queued, not-yet-granted emergency lanes.

Behaviour:
- Clocking: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: emgSignal=0, emgLane=0, pedSignal=0, pending=0. Also cleared: round-robin pointer=0, FSM=IDLE, all counters=0, edge-detect history=0, ped latch=0, ped armed=1.
- Reset mid-operation: reset wins over every other event; any in-progress grant and all pending lanes are discarded.
- Edge detect: pending[i] sets on a rising edge of emgDetect[i] (current sample 1, registered previous sample 0). A level held high does not re-queue the lane.
- Pending clear: pending[i] clears on the edge where lane i is granted. If a new rising edge on lane i occurs in the same cycle, the set wins.
- FSM IDLE: if pending!=0, select a lane, load the hold counter with HOLD_CYCLES-1, go to HOLD. Otherwise stay in IDLE.
- Selection: round-robin. Search starts at the pointer and ascends modulo 8. After a grant of lane g, pointer=(g+1) mod 8.
- FSM HOLD: emgSignal=1, emgLane=one-hot(g). When the counter reaches 0: go to GAP loaded with GAP_CYCLES-1, or go straight to IDLE if GAP_CYCLES=0. Otherwise decrement the counter.
- FSM GAP: emgSignal=0, emgLane=0. When the counter reaches 0, go to IDLE.
- Grant latency: rising edge on emgDetect sampled at edge t -> pending visible after t -> emgSignal high after edge t+1 for exactly HOLD_CYCLES cycles.
- Back-to-back grants are separated by GAP_CYCLES + 1 low cycles (GAP plus one IDLE cycle).
- Outputs emgSignal and emgLane are registered; no combinational input-to-output paths.
- Pedestrian debounce:
  - The 8-bit debounce counter increments on each sample with pedButton=1 and clears to 0 on pedButton=0. It saturates and does not wrap.
  - On the edge where the counter would reach DEB_CYCLES while armed=1: ped latch sets and armed clears.
  - armed sets again only when pedButton is sampled 0. One press produces at most one request.
- pedClear clears the ped latch. If it coincides with the set event, the set wins.
- pedSignal = ped latch AND NOT emgSignal. The latch itself is retained during an emergency.
- pedClear during an emergency still clears the latch.

Optional Feature:
- Macro: EMG_FIXED_PRIORITY_EN.
- Defined: selection is fixed priority, lowest pending index wins. The pointer is unused and stays 0.
- Undefined (default): round-robin as described in Behaviour.
- All other timing is identical in both builds.

Test Plan:
1. Reset with rst=1 for 2 cycles, all inputs 0 -> emgSignal=0, emgLane=8'b00000000, pedSignal=0, pending=0. Outputs remain there for 10 cycles after rst=0.
2. Single lane: emgDetect=8'b00001000 raised at edge 0 and held -> pending=8'b00001000 after edge 0. emgSignal=1 with emgLane=8'b00001000 for 4 cycles (after edges 1..4). Low for 3 cycles. No second grant.
3. Round robin vs priority: pulse lanes 1 and 6 together -> grants lane 1, then lane 6, spaced 3 low cycles apart. Then pulse lanes 1 and 7 together -> default build grants 7 then 1; EMG_FIXED_PRIORITY_EN build grants 1 then 7.
4. Pedestrian debounce:
   - pedButton high 2 cycles then low -> pedSignal stays 0.
   - pedButton high 3 cycles -> pedSignal=1 after the 3rd high sample; holding the button 20 more cycles gives no retrigger.
   - pedClear pulse -> pedSignal=0 next cycle.
   - Release, then press 3 cycles -> pedSignal=1 again.
5. Masking: ped latch set, then emergency on lane 0 -> pedSignal=0 during the 4 HOLD cycles, returns to 1 after with no pedClear. If pedClear pulses during HOLD -> pedSignal stays 0 after.
6. Reset mid-HOLD: lanes 2 and 5 pending, assert rst in 2nd HOLD cycle -> next cycle emgSignal=0, emgLane=0, pending=0. No grant follows rst deassertion.

Source files
------------

// File: rtl/request_arbiter.sv
// Emergency-lane arbiter and pedestrian button conditioner for the traffic-light controller.
// Optional build macro EMG_FIXED_PRIORITY_EN: lowest pending lane wins instead of round-robin.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   emgDetect  raw per-lane emergency detect lines (bit i = lane i)
//   pedButton  raw pedestrian push-button level
//   pedClear   one-cycle pulse: pedestrian phase served
//   emgSignal  registered emergency request
//   emgLane    registered one-hot granted lane, zero when idle
//   pedSignal  latched pedestrian request, masked while emgSignal is high
//   pending    emergency lanes queued but not yet granted

module request_arbiter #(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 2,
    parameter int DEB_CYCLES  = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] emgDetect,
    input  logic       pedButton,
    input  logic       pedClear,
    output logic       emgSignal,
    output logic [7:0] emgLane,
    output logic       pedSignal,
    output logic [7:0] pending
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } arbState_t;

    localparam logic [7:0] HOLD_LOAD  = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] GAP_LOAD   = 8'(GAP_CYCLES - 1);
    localparam logic [8:0] DEB_TARGET = 9'(DEB_CYCLES);

    arbState_t  state;
    arbState_t  stateNext;
    logic [7:0] holdCnt;
    logic [7:0] cntNext;
    logic [2:0] ptr;
    logic [2:0] ptrNext;
    logic [7:0] detPrev;
    logic [7:0] rise;
    logic [7:0] grantMask;
    logic [7:0] laneNext;
    logic [7:0] pendingNext;
    logic [2:0] searchIdx;
    logic [2:0] selIdx;
    logic       selValid;

    logic [7:0] debCnt;
    logic       armed;
    logic       pedLatch;
    logic       pedSet;

    assign rise = emgDetect & ~detPrev;

    // Search upward from the pointer, wrapping at 8. In the fixed-priority
    // build the pointer never moves off 0, so this is lowest-index-first.
    always_comb begin
        selIdx    = '0;
        selValid  = 1'b0;
        searchIdx = '0;
        for (int i = 0; i < 8; i++) begin
            searchIdx = ptr + 3'(i);
            if (!selValid && pending[searchIdx]) begin
                selIdx   = searchIdx;
                selValid = 1'b1;
            end
        end
    end

    always_comb begin
        stateNext = state;
        cntNext   = holdCnt;
        ptrNext   = ptr;
        grantMask = '0;
        laneNext  = emgLane;
        unique case (state)
            IDLE: begin
                if (selValid) begin
                    stateNext = HOLD;
                    cntNext   = HOLD_LOAD;
                    grantMask = 8'(1) << selIdx;
                    laneNext  = 8'(1) << selIdx;
`ifdef EMG_FIXED_PRIORITY_EN
                    ptrNext   = '0;
`else
                    ptrNext   = selIdx + 3'd1;
`endif
                end
            end
            HOLD: begin
                if (holdCnt == 8'd0) begin
                    laneNext = '0;
                    if (GAP_CYCLES == 0) begin
                        stateNext = IDLE;
                    end else begin
                        stateNext = GAP;
                        cntNext   = GAP_LOAD;
                    end
                end else begin
                    cntNext = holdCnt - 8'd1;
                end
            end
            GAP: begin
                if (holdCnt == 8'd0) begin
                    stateNext = IDLE;
                end else begin
                    cntNext = holdCnt - 8'd1;
                end
            end
            default: begin
                stateNext = IDLE;
                laneNext  = '0;
            end
        endcase
    end

    // A fresh rising edge beats the grant clear on the same lane.
    assign pendingNext = (pending & ~grantMask) | rise;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            holdCnt   <= '0;
            ptr       <= '0;
            detPrev   <= '0;
            pending   <= '0;
            emgSignal <= 1'b0;
            emgLane   <= '0;
        end else begin
            state     <= stateNext;
            holdCnt   <= cntNext;
            ptr       <= ptrNext;
            detPrev   <= emgDetect;
            pending   <= pendingNext;
            emgSignal <= (stateNext == HOLD);
            emgLane   <= laneNext;
        end
    end

    // Fires once per press: armed drops on the set and only returns
    // after the button is seen released.
    assign pedSet = pedButton && armed &&
                    (({1'b0, debCnt} + 9'd1) == DEB_TARGET);

    always_ff @(posedge clk) begin
        if (rst) begin
            debCnt   <= '0;
            armed    <= 1'b1;
            pedLatch <= 1'b0;
        end else begin
            if (pedButton) begin
                if (debCnt != 8'hFF) begin
                    debCnt <= debCnt + 8'd1;
                end
            end else begin
                debCnt <= '0;
            end
            if (pedSet) begin
                pedLatch <= 1'b1;
                armed    <= 1'b0;
            end else begin
                if (pedClear) begin
                    pedLatch <= 1'b0;
                end
                if (!pedButton) begin
                    armed <= 1'b1;
                end
            end
        end
    end

    assign pedSignal = pedLatch & ~emgSignal;

endmodule

// File: tb/tb_request_arbiter.sv
// Self-checking bench for request_arbiter: vector table plus hand-written corner sequences.
// Expectations are queued when a cycle is driven and compared after its clock edge.

module tb_request_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] emgDetect;
    logic       pedButton;
    logic       pedClear;
    logic       emgSignal;
    logic [7:0] emgLane;
    logic       pedSignal;
    logic [7:0] pending;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        logic       rst;
        logic [7:0] det;
        logic       btn;
        logic       clr;
        int         n;
        logic       eSig;
        logic [7:0] eLane;
        logic       ped;
        logic [7:0] pend;
    } vec_t;

    typedef struct {
        logic       eSig;
        logic [7:0] eLane;
        logic       ped;
        logic [7:0] pend;
        string      tag;
    } exp_t;

    vec_t vecs[$];
    exp_t expQ[$];

`ifdef EMG_FIXED_PRIORITY_EN
    localparam logic [7:0] FIRST  = 8'h02;
    localparam logic [7:0] SECOND = 8'h80;
`else
    localparam logic [7:0] FIRST  = 8'h80;
    localparam logic [7:0] SECOND = 8'h02;
`endif

    request_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .emgDetect (emgDetect),
        .pedButton (pedButton),
        .pedClear  (pedClear),
        .emgSignal (emgSignal),
        .emgLane   (emgLane),
        .pedSignal (pedSignal),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    task automatic add(input logic r, input logic [7:0] d, input logic b,
                       input logic c, input int n, input logic s,
                       input logic [7:0] l, input logic p,
                       input logic [7:0] q);
        vec_t v;
        v.rst = r; v.det = d; v.btn = b; v.clr = c; v.n = n;
        v.eSig = s; v.eLane = l; v.ped = p; v.pend = q;
        vecs.push_back(v);
    endtask

    task automatic step(input logic r, input logic [7:0] d, input logic b,
                        input logic c, input logic s, input logic [7:0] l,
                        input logic p, input logic [7:0] q,
                        input string tag);
        exp_t e;
        rst = r; emgDetect = d; pedButton = b; pedClear = c;
        e.eSig = s; e.eLane = l; e.ped = p; e.pend = q; e.tag = tag;
        expQ.push_back(e);
        @(posedge clk);
        #1;
        e = expQ.pop_front();
        checks++;
        if (emgSignal !== e.eSig) begin
            fails++;
            $display("FAIL %s emgSignal got %0b exp %0b", e.tag, emgSignal, e.eSig);
        end
        checks++;
        if (emgLane !== e.eLane) begin
            fails++;
            $display("FAIL %s emgLane got %h exp %h", e.tag, emgLane, e.eLane);
        end
        checks++;
        if (pedSignal !== e.ped) begin
            fails++;
            $display("FAIL %s pedSignal got %0b exp %0b", e.tag, pedSignal, e.ped);
        end
        checks++;
        if (pending !== e.pend) begin
            fails++;
            $display("FAIL %s pending got %h exp %h", e.tag, pending, e.pend);
        end
    endtask

    initial begin
        rst = 1'b1; emgDetect = '0; pedButton = 1'b0; pedClear = 1'b0;

        // reset and quiet period
        add(1, 8'h00, 0, 0,  2, 0, 8'h00, 0, 8'h00);
        add(0, 8'h00, 0, 0, 10, 0, 8'h00, 0, 8'h00);
        // single lane held high: one grant only
        add(0, 8'h08, 0, 0,  1, 0, 8'h00, 0, 8'h08);
        add(0, 8'h08, 0, 0,  4, 1, 8'h08, 0, 8'h00);
        add(0, 8'h08, 0, 0,  6, 0, 8'h00, 0, 8'h00);
        add(0, 8'h00, 0, 0,  2, 0, 8'h00, 0, 8'h00);
        // lanes 1 and 6 from pointer 0
        add(1, 8'h00, 0, 0,  1, 0, 8'h00, 0, 8'h00);
        add(0, 8'h42, 0, 0,  1, 0, 8'h00, 0, 8'h42);
        add(0, 8'h00, 0, 0,  4, 1, 8'h02, 0, 8'h40);
        add(0, 8'h00, 0, 0,  3, 0, 8'h00, 0, 8'h40);
        add(0, 8'h00, 0, 0,  4, 1, 8'h40, 0, 8'h00);
        add(0, 8'h00, 0, 0,  3, 0, 8'h00, 0, 8'h00);
        // lanes 1 and 7: order depends on arbitration mode
        add(0, 8'h82, 0, 0,  1, 0, 8'h00, 0, 8'h82);
        add(0, 8'h00, 0, 0,  4, 1, FIRST, 0, SECOND);
        add(0, 8'h00, 0, 0,  3, 0, 8'h00, 0, SECOND);
        add(0, 8'h00, 0, 0,  4, 1, SECOND, 0, 8'h00);
        add(0, 8'h00, 0, 0,  3, 0, 8'h00, 0, 8'h00);
        // pedestrian debounce
        add(0, 8'h00, 1, 0,  2, 0, 8'h00, 0, 8'h00);
        add(0, 8'h00, 0, 0,  1, 0, 8'h00, 0, 8'h00);
        add(0, 8'h00, 1, 0,  2, 0, 8'h00, 0, 8'h00);
        add(0, 8'h00, 1, 0, 21, 0, 8'h00, 1, 8'h00);
        add(0, 8'h00, 1, 1,  1, 0, 8'h00, 0, 8'h00);
        add(0, 8'h00, 1, 0,  2, 0, 8'h00, 0, 8'h00);
        add(0, 8'h00, 0, 0,  1, 0, 8'h00, 0, 8'h00);
        add(0, 8'h00, 1, 0,  2, 0, 8'h00, 0, 8'h00);
        add(0, 8'h00, 1, 0,  1, 0, 8'h00, 1, 8'h00);
        add(0, 8'h00, 0, 0,  1, 0, 8'h00, 1, 8'h00);
        // masking by emergency, latch kept
        add(0, 8'h01, 0, 0,  1, 0, 8'h00, 1, 8'h01);
        add(0, 8'h00, 0, 0,  4, 1, 8'h01, 0, 8'h00);
        add(0, 8'h00, 0, 0,  3, 0, 8'h00, 1, 8'h00);
        // pedClear during HOLD
        add(0, 8'h01, 0, 0,  1, 0, 8'h00, 1, 8'h01);
        add(0, 8'h00, 0, 0,  1, 1, 8'h01, 0, 8'h00);
        add(0, 8'h00, 0, 1,  1, 1, 8'h01, 0, 8'h00);
        add(0, 8'h00, 0, 0,  2, 1, 8'h01, 0, 8'h00);
        add(0, 8'h00, 0, 0,  3, 0, 8'h00, 0, 8'h00);
        // reset in second HOLD cycle drops grant and queue
        add(0, 8'h24, 0, 0,  1, 0, 8'h00, 0, 8'h24);
        add(0, 8'h00, 0, 0,  1, 1, 8'h04, 0, 8'h20);
        add(1, 8'h00, 0, 0,  1, 0, 8'h00, 0, 8'h00);
        add(0, 8'h00, 0, 0, 12, 0, 8'h00, 0, 8'h00);

        foreach (vecs[i]) begin
            for (int k = 0; k < vecs[i].n; k++) begin
                step(vecs[i].rst, vecs[i].det, vecs[i].btn, vecs[i].clr,
                     vecs[i].eSig, vecs[i].eLane, vecs[i].ped,
                     vecs[i].pend, $sformatf("v%0d.%0d", i, k));
            end
        end

        // rising edge on the lane being granted keeps it pending
        step(0, 8'h01, 0, 0, 0, 8'h00, 0, 8'h01, "setwin.q0");
        step(0, 8'h00, 0, 0, 1, 8'h01, 0, 8'h00, "setwin.g0");
        step(0, 8'h08, 0, 0, 1, 8'h01, 0, 8'h08, "setwin.q3");
        for (int k = 0; k < 2; k++)
            step(0, 8'h00, 0, 0, 1, 8'h01, 0, 8'h08, "setwin.hold");
        for (int k = 0; k < 3; k++)
            step(0, 8'h00, 0, 0, 0, 8'h00, 0, 8'h08, "setwin.gap");
        step(0, 8'h08, 0, 0, 1, 8'h08, 0, 8'h08, "setwin.g3");
        step(0, 8'h08, 0, 0, 1, 8'h08, 0, 8'h08, "setwin.h3");
        step(1, 8'h00, 0, 0, 0, 8'h00, 0, 8'h00, "setwin.rst");

        // ped set coinciding with pedClear: set wins
        step(0, 8'h00, 1, 0, 0, 8'h00, 0, 8'h00, "pedwin.b1");
        step(0, 8'h00, 1, 0, 0, 8'h00, 0, 8'h00, "pedwin.b2");
        step(0, 8'h00, 1, 1, 0, 8'h00, 1, 8'h00, "pedwin.set");
        step(0, 8'h00, 0, 1, 0, 8'h00, 0, 8'h00, "pedwin.clr");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
